// File: rtl/aes_pkg.sv
// Shared AES types, round constants and key-schedule localparams.
// AES_EQ_INV_KEY_EN adds the column-wise InvMixColumns helper used by the equivalent inverse schedule.
package aes_pkg;

    localparam int NR = 10;
    localparam int NK = 4;
    localparam int NW = 44;

    typedef logic [0:127] state_t;
    typedef logic [31:0]  word_t;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        READY
    } key_fsm_e;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

`ifdef AES_EQ_INV_KEY_EN
    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte 0 of the column sits in w[31:24].
    function automatic word_t invMixWord(input word_t w);
        logic [7:0] a  [4];
        logic [7:0] m2 [4];
        logic [7:0] m4 [4];
        logic [7:0] m8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = w[31-8*i -: 8];
            m2[i] = xtime(a[i]);
            m4[i] = xtime(m2[i]);
            m8[i] = xtime(m4[i]);
            m9[i] = m8[i] ^ a[i];
            mb[i] = m8[i] ^ m2[i] ^ a[i];
            md[i] = m8[i] ^ m4[i] ^ a[i];
            me[i] = m8[i] ^ m4[i] ^ m2[i];
        end
        invMixWord = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                      m9[0] ^ me[1] ^ mb[2] ^ md[3],
                      md[0] ^ m9[1] ^ me[2] ^ mb[3],
                      mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction
`endif

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte in and one byte out.
// Shared by the key schedule SubWord and the encryption SubBytes stage.
module aes_sbox (
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    localparam logic [0:2047] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign byte_o = SBOX_TBL[{byte_i, 3'b000} +: 8];

endmodule

// File: rtl/aes_inv_add_round_key.sv
// Decryption AddRoundKey stage with an on-chip AES-128 key schedule built one word per clock.
// Define AES_EQ_INV_KEY_EN to store InvMixColumns-transformed keys for rounds 1..9 (equivalent inverse cipher).
module aes_inv_add_round_key
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         keyValid,
    output logic         keyReady,
    input  logic [0:127] keyIn,
    output logic         keyDone,
    input  logic         inValid,
    output logic         inReady,
    input  logic [0:127] stateIn,
    input  logic [3:0]   inRound,
    output logic         outValid,
    input  logic         outReady,
    output logic [0:127] stateOut,
    output logic [3:0]   outRound,
    output logic         outLast,
    output logic         outErr
);

    key_fsm_e    state_q;
    logic [5:0]  cnt_q;
    logic        keyDone_q;

    word_t       w_q   [NW];
    word_t       win_q [4];

    state_t      stateOut_q, stateOut_d;
    logic [3:0]  outRound_q, outRound_d;
    logic        outLast_q,  outLast_d;
    logic        outErr_q,   outErr_d;
    logic        outValid_q, outValid_d;

    logic        keyAccept, inAccept, drain, badRound;
    logic [3:0]  rkSel;
    state_t      roundKey;
    word_t       rotWord, subWord, tWord, newWord, storeWord;

    assign keyReady  = (state_q == IDLE || state_q == READY) && !outValid_q;
    assign inReady   = (state_q == READY) && (!outValid_q || outReady);
    assign keyAccept = keyValid && keyReady;
    assign inAccept  = inValid && inReady;
    assign drain     = outValid_q && outReady;

    // win_q[0] is w[i-4] and win_q[3] is w[i-1], always in untransformed form.
    assign rotWord = {win_q[3][23:0], win_q[3][31:24]};

    for (genvar g = 0; g < 4; g++) begin : gSubWord
        aes_sbox uSbox (
            .byte_i (rotWord[8*g +: 8]),
            .byte_o (subWord[8*g +: 8])
        );
    end

    assign tWord   = (cnt_q[1:0] == 2'b00) ? (subWord ^ {rcon(cnt_q[5:2]), 24'h0}) : win_q[3];
    assign newWord = win_q[0] ^ tWord;

`ifdef AES_EQ_INV_KEY_EN
    assign storeWord = (cnt_q < 6'(NW - NK)) ? invMixWord(newWord) : newWord;
`else
    assign storeWord = newWord;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            keyDone_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, READY: begin
                    if (keyAccept) begin
                        keyDone_q <= 1'b0;
                        cnt_q     <= 6'(NK);
                        state_q   <= EXPAND;
                    end
                end
                EXPAND: begin
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'(NW - 1)) begin
                        keyDone_q <= 1'b1;
                        state_q   <= READY;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Key words are not reset; keyDone gates every use of them.
    always_ff @(posedge clk) begin
        if (keyAccept) begin
            for (int k = 0; k < 4; k++) begin
                w_q[k]   <= keyIn[32*k +: 32];
                win_q[k] <= keyIn[32*k +: 32];
            end
        end else if (state_q == EXPAND) begin
            w_q[cnt_q] <= storeWord;
            win_q[0]   <= win_q[1];
            win_q[1]   <= win_q[2];
            win_q[2]   <= win_q[3];
            win_q[3]   <= newWord;
        end
    end

    assign badRound = inRound > 4'(NR);
    assign rkSel    = badRound ? 4'd0 : inRound;
    assign roundKey = {w_q[{rkSel, 2'b00}], w_q[{rkSel, 2'b01}],
                       w_q[{rkSel, 2'b10}], w_q[{rkSel, 2'b11}]};

    always_comb begin
        stateOut_d = stateOut_q;
        outRound_d = outRound_q;
        outLast_d  = outLast_q;
        outErr_d   = outErr_q;
        outValid_d = outValid_q;
        if (inAccept) begin
            stateOut_d = badRound ? stateIn : (stateIn ^ roundKey);
            outRound_d = inRound;
            outLast_d  = (inRound == 4'd0);
            outErr_d   = badRound;
            outValid_d = 1'b1;
        end else if (drain) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateOut_q <= '0;
            outRound_q <= '0;
            outLast_q  <= 1'b0;
            outErr_q   <= 1'b0;
            outValid_q <= 1'b0;
        end else begin
            stateOut_q <= stateOut_d;
            outRound_q <= outRound_d;
            outLast_q  <= outLast_d;
            outErr_q   <= outErr_d;
            outValid_q <= outValid_d;
        end
    end

    assign keyDone  = keyDone_q;
    assign outValid = outValid_q;
    assign stateOut = stateOut_q;
    assign outRound = outRound_q;
    assign outLast  = outLast_q;
    assign outErr   = outErr_q;

endmodule

// File: tb/tb_aes_inv_add_round_key.sv
// Directed-vector bench for aes_inv_add_round_key using FIPS-197 key schedules.
// Round-1 expectation follows AES_EQ_INV_KEY_EN so the same bench covers both builds.
module tb_aes_inv_add_round_key;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         keyValid;
    logic         keyReady;
    logic [0:127] keyIn;
    logic         keyDone;
    logic         inValid;
    logic         inReady;
    logic [0:127] stateIn;
    logic [3:0]   inRound;
    logic         outValid;
    logic         outReady;
    logic [0:127] stateOut;
    logic [3:0]   outRound;
    logic         outLast;
    logic         outErr;

    int numChecks;
    int numFails;

    localparam logic [0:127] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [0:127] SEQ_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] SEQ_RK10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
`ifdef AES_EQ_INV_KEY_EN
    localparam logic [0:127] FIPS_RK1  = 128'h2b3708a7f262d405bc3ebdbf4b617d62;
`else
    localparam logic [0:127] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
`endif

    aes_inv_add_round_key dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .keyValid (keyValid),
        .keyReady (keyReady),
        .keyIn    (keyIn),
        .keyDone  (keyDone),
        .inValid  (inValid),
        .inReady  (inReady),
        .stateIn  (stateIn),
        .inRound  (inRound),
        .outValid (outValid),
        .outReady (outReady),
        .stateOut (stateOut),
        .outRound (outRound),
        .outLast  (outLast),
        .outErr   (outErr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Loads a key and waits for keyDone; optionally keeps keyValid high with a bogus key during EXPAND.
    task automatic loadKey(input logic [0:127] key, input bit jam, output int cycles, output int readyLeaks);
        keyIn    = key;
        keyValid = 1'b1;
        tick();
        if (jam) keyIn = ~key;
        else     keyValid = 1'b0;
        cycles     = 0;
        readyLeaks = 0;
        while (!keyDone && cycles < 200) begin
            if (inReady) readyLeaks++;
            if (cycles == 3) keyValid = 1'b0;
            tick();
            cycles++;
        end
        keyValid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        keyValid = 1'b0;
        keyIn    = '0;
        inValid  = 1'b0;
        stateIn  = '0;
        inRound  = '0;
        outReady = 1'b0;
        repeat (2) tick();
        numChecks++;
        if ({keyDone, outValid, outLast, outErr, inReady, keyReady} !== 6'b000001) begin
            numFails++;
            $display("[TB] FAIL resetFlags: got %b, expected 000001", {keyDone, outValid, outLast, outErr, inReady, keyReady});
        end
        numChecks++;
        if (stateOut !== 128'h0) begin
            numFails++;
            $display("[TB] FAIL resetStateOut: got %h, expected 0", stateOut);
        end
        numChecks++;
        if (outRound !== 4'd0) begin
            numFails++;
            $display("[TB] FAIL resetOutRound: got %0d, expected 0", outRound);
        end
        rst_n = 1'b1;
        tick();
        numChecks++;
        if (inReady !== 1'b0) begin
            numFails++;
            $display("[TB] FAIL idleInReady: got %b, expected 0", inReady);
        end
    endtask

    task automatic test_key_expansion();
        int cycles, leaks;
        numChecks++;
        if (keyReady !== 1'b1) begin
            numFails++;
            $display("[TB] FAIL idleKeyReady: got %b, expected 1", keyReady);
        end
        loadKey(FIPS_KEY, 1'b0, cycles, leaks);
        numChecks++;
        if (cycles !== 40) begin
            numFails++;
            $display("[TB] FAIL keyDoneLatency: got %0d cycles, expected 40", cycles);
        end
        numChecks++;
        if (leaks !== 0) begin
            numFails++;
            $display("[TB] FAIL inReadyDuringExpand: got %0d cycles high, expected 0", leaks);
        end
        outReady = 1'b1;
        stateIn  = '0;
        inRound  = 4'd1;
        inValid  = 1'b1;
        numChecks++;
        if (inReady !== 1'b1) begin
            numFails++;
            $display("[TB] FAIL readyInReady: got %b, expected 1", inReady);
        end
        tick();
        inRound = 4'd10;
        numChecks++;
        if (stateOut !== FIPS_RK1) begin
            numFails++;
            $display("[TB] FAIL fipsRound1: got %h, expected %h", stateOut, FIPS_RK1);
        end
        numChecks++;
        if ({outValid, outLast, outErr, outRound} !== {3'b100, 4'd1}) begin
            numFails++;
            $display("[TB] FAIL fipsRound1Tags: got %b, expected 1000001", {outValid, outLast, outErr, outRound});
        end
        tick();
        inValid = 1'b0;
        numChecks++;
        if (stateOut !== FIPS_RK10) begin
            numFails++;
            $display("[TB] FAIL fipsRound10: got %h, expected %h", stateOut, FIPS_RK10);
        end
        numChecks++;
        if ({outValid, outLast, outErr, outRound} !== {3'b100, 4'd10}) begin
            numFails++;
            $display("[TB] FAIL fipsRound10Tags: got %b, expected 1001010", {outValid, outLast, outErr, outRound});
        end
        tick();
        numChecks++;
        if (outValid !== 1'b0) begin
            numFails++;
            $display("[TB] FAIL drainOutValid: got %b, expected 0", outValid);
        end
    endtask

    task automatic test_second_key();
        int cycles, leaks;
        logic [0:127] exp10;
        numChecks++;
        if (keyReady !== 1'b1) begin
            numFails++;
            $display("[TB] FAIL reloadKeyReady: got %b, expected 1", keyReady);
        end
        loadKey(SEQ_KEY, 1'b1, cycles, leaks);
        numChecks++;
        if (cycles !== 40 || leaks !== 0) begin
            numFails++;
            $display("[TB] FAIL reloadLatency: got %0d cycles / %0d leaks, expected 40 / 0", cycles, leaks);
        end
        exp10   = ~SEQ_RK10;
        stateIn = {128{1'b1}};
        inRound = 4'd10;
        inValid = 1'b1;
        tick();
        inRound = 4'd0;
        numChecks++;
        if (stateOut !== exp10 || outLast !== 1'b0) begin
            numFails++;
            $display("[TB] FAIL seqRound10: got %h last %b, expected %h last 0", stateOut, outLast, exp10);
        end
        tick();
        inValid = 1'b0;
        numChecks++;
        if (stateOut !== 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0 || outLast !== 1'b1 || outRound !== 4'd0) begin
            numFails++;
            $display("[TB] FAIL seqRound0: got %h last %b round %0d, expected fffefdfcfbfaf9f8f7f6f5f4f3f2f1f0 last 1 round 0",
                     stateOut, outLast, outRound);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [0:127] s [4];
        logic [3:0]   r [4];
        logic [0:127] e [4];
        s[0] = 128'h00112233445566778899aabbccddeeff;
        s[1] = {128{1'b1}};
        s[2] = 128'h0;
        s[3] = 128'h0123456789abcdeffedcba9876543210;
        r[0] = 4'd0;
        r[1] = 4'd10;
        r[2] = 4'd10;
        r[3] = 4'd0;
        for (int k = 0; k < 4; k++) e[k] = s[k] ^ ((r[k] == 4'd0) ? SEQ_KEY : SEQ_RK10);
        outReady = 1'b0;
        stateIn  = s[0];
        inRound  = r[0];
        inValid  = 1'b1;
        tick();
        stateIn = s[1];
        inRound = r[1];
        for (int c = 0; c < 5; c++) begin
            tick();
            numChecks++;
            if (stateOut !== e[0] || outRound !== r[0] || outValid !== 1'b1 || inReady !== 1'b0) begin
                numFails++;
                $display("[TB] FAIL stall%0d: got %h round %0d valid %b inReady %b, expected %h round %0d valid 1 inReady 0",
                         c, stateOut, outRound, outValid, inReady, e[0], r[0]);
            end
        end
        outReady = 1'b1;
        for (int k = 1; k < 4; k++) begin
            tick();
            numChecks++;
            if (stateOut !== e[k] || outRound !== r[k] || outValid !== 1'b1) begin
                numFails++;
                $display("[TB] FAIL burst%0d: got %h round %0d valid %b, expected %h round %0d valid 1",
                         k, stateOut, outRound, outValid, e[k], r[k]);
            end
            if (k < 3) begin
                stateIn = s[k+1];
                inRound = r[k+1];
            end else begin
                inValid = 1'b0;
            end
        end
        tick();
        numChecks++;
        if (outValid !== 1'b0) begin
            numFails++;
            $display("[TB] FAIL burstDrain: got %b, expected 0", outValid);
        end
    endtask

    task automatic test_bad_round();
        outReady = 1'b1;
        stateIn  = 128'h0123456789abcdef0123456789abcdef;
        inRound  = 4'd12;
        inValid  = 1'b1;
        tick();
        stateIn = {128{1'b1}};
        inRound = 4'd15;
        numChecks++;
        if (stateOut !== 128'h0123456789abcdef0123456789abcdef || {outErr, outLast} !== 2'b10 || outRound !== 4'd12) begin
            numFails++;
            $display("[TB] FAIL round12: got %h err/last %b round %0d, expected 0123456789abcdef0123456789abcdef err/last 10 round 12",
                     stateOut, {outErr, outLast}, outRound);
        end
        tick();
        stateIn = '0;
        inRound = 4'd0;
        numChecks++;
        if (stateOut !== {128{1'b1}} || {outErr, outLast} !== 2'b10) begin
            numFails++;
            $display("[TB] FAIL round15: got %h err/last %b, expected all ones err/last 10", stateOut, {outErr, outLast});
        end
        tick();
        inValid = 1'b0;
        numChecks++;
        if (stateOut !== SEQ_KEY || {outErr, outLast} !== 2'b01) begin
            numFails++;
            $display("[TB] FAIL errClears: got %h err/last %b, expected %h err/last 01", stateOut, {outErr, outLast}, SEQ_KEY);
        end
        tick();
    endtask

    task automatic test_reset_mid_expand();
        int cycles, leaks, idleLeaks;
        keyIn    = FIPS_KEY;
        keyValid = 1'b1;
        tick();
        keyValid = 1'b0;
        repeat (19) tick();
        #2;
        rst_n = 1'b0;
        #1;
        numChecks++;
        if (stateOut !== 128'h0 || outRound !== 4'd0 || {keyDone, outValid, outLast, outErr, inReady} !== 5'b0) begin
            numFails++;
            $display("[TB] FAIL asyncReset: got %h round %0d flags %b, expected 0 round 0 flags 00000",
                     stateOut, outRound, {keyDone, outValid, outLast, outErr, inReady});
        end
        tick();
        rst_n = 1'b1;
        idleLeaks = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (inReady !== 1'b0 || keyDone !== 1'b0) idleLeaks++;
        end
        numChecks++;
        if (idleLeaks !== 0) begin
            numFails++;
            $display("[TB] FAIL abortedSchedule: got %0d cycles with inReady/keyDone high, expected 0", idleLeaks);
        end
        loadKey(FIPS_KEY, 1'b0, cycles, leaks);
        numChecks++;
        if (cycles !== 40 || leaks !== 0) begin
            numFails++;
            $display("[TB] FAIL rebuildLatency: got %0d cycles / %0d leaks, expected 40 / 0", cycles, leaks);
        end
        outReady = 1'b1;
        stateIn  = '0;
        inRound  = 4'd10;
        inValid  = 1'b1;
        tick();
        inRound = 4'd1;
        numChecks++;
        if (stateOut !== FIPS_RK10) begin
            numFails++;
            $display("[TB] FAIL rebuildRound10: got %h, expected %h", stateOut, FIPS_RK10);
        end
        tick();
        inRound = 4'd0;
        numChecks++;
        if (stateOut !== FIPS_RK1) begin
            numFails++;
            $display("[TB] FAIL rebuildRound1: got %h, expected %h", stateOut, FIPS_RK1);
        end
        tick();
        inValid = 1'b0;
        numChecks++;
        if (stateOut !== FIPS_KEY || outLast !== 1'b1) begin
            numFails++;
            $display("[TB] FAIL rebuildRound0: got %h last %b, expected %h last 1", stateOut, outLast, FIPS_KEY);
        end
        tick();
    endtask

    initial begin
        numChecks = 0;
        numFails  = 0;
        test_reset();
        test_key_expansion();
        test_second_key();
        test_backpressure();
        test_bad_round();
        test_reset_mid_expand();
        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached before the bench completed");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
